// File: rtl/aes192_wordio_pkg.sv
// Shared constants and state encoding for the AES-192 word-serial adapter.
// Widths are fixed by the 32-bit host bus and the AES-192 key/block sizes.
package aes192_wordio_pkg;

  localparam int HOST_W     = 32;
  localparam int KEY_W      = 192;
  localparam int BLK_W      = 128;
  localparam int KEY_WORDS  = 6;
  localparam int DATA_WORDS = 4;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_LOAD    = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

endpackage

// File: rtl/aes192_word_ser.sv
// 128-bit to 4x32-bit result serializer, most significant word first.
// Holds word and last stable while the sink stalls.
module aes192_word_ser
  import aes192_wordio_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [BLK_W-1:0]  blk,
  output logic              valid,
  input  logic              ready,
  output logic [HOST_W-1:0] word,
  output logic              last,
  output logic              done
);

  logic [DATA_WORDS-1:0][HOST_W-1:0] blk_q;
  logic [1:0]                        ocnt;

  // ~ocnt maps count 0 to the top (MS) word
  assign word = blk_q[~ocnt];
  assign last = valid & (ocnt == 2'd3);
  assign done = valid & ready & (ocnt == 2'd3);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_q <= '0;
      ocnt  <= 2'd0;
      valid <= 1'b0;
    end else if (load) begin
      blk_q <= blk;
      ocnt  <= 2'd0;
      valid <= 1'b1;
    end else if (valid && ready) begin
      ocnt <= ocnt + 2'd1;
      if (ocnt == 2'd3)
        valid <= 1'b0;
    end
  end

endmodule

// File: rtl/aes192_wordio.sv
// Word-serial host adapter in front of and behind an AES-192 core.
// Collects key/data words, launches the core, streams the result back.
module aes192_wordio
  import aes192_wordio_pkg::*;
#(
  parameter int WORD_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WORD_W-1:0] in_word_i,
  input  logic              in_key_i,
  input  logic              in_decrypt_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WORD_W-1:0] out_word_o,
  output logic              out_last_o,
  output logic              core_load_o,
  output logic              core_decrypt_o,
  output logic [BLK_W-1:0]  core_data_o,
  output logic [KEY_W-1:0]  core_key_o,
  input  logic              core_ready_i,
  input  logic [BLK_W-1:0]  core_data_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t                            state;
  logic [2:0]                        kcnt;
  logic [1:0]                        dcnt;
  logic                              key_valid;
  logic [TW-1:0]                     tcnt;
  logic [KEY_WORDS-1:0][HOST_W-1:0]  key_q;
  logic [DATA_WORDS-1:0][HOST_W-1:0] data_q;
  logic                              dec_q;
  logic                              err_q;

  logic acc;
  logic key_acc;
  logic data_acc;
  logic last_data;
  logic bad_blk;
  logic cap;
  logic tmo;
  logic done;

  assign in_ready_o     = (state == ST_COLLECT);
  assign busy_o         = (state != ST_COLLECT);
  assign core_load_o    = (state == ST_LOAD);
  assign core_key_o     = key_q;
  assign core_data_o    = data_q;
  assign core_decrypt_o = dec_q;
  assign err_o          = err_q;

  assign acc       = in_valid_i & in_ready_o;
  assign key_acc   = acc & in_key_i;
  assign data_acc  = acc & ~in_key_i;
  assign last_data = data_acc & (dcnt == 2'd3);
  assign bad_blk   = last_data & ~key_valid;
  assign cap       = (state == ST_WAIT) & core_ready_i;
  // ready in the final WAIT cycle takes priority over the timeout
  assign tmo = (state == ST_WAIT) & ~core_ready_i
             & (tcnt == TW'(TIMEOUT_CYC - 1));

  aes192_word_ser u_ser (
    .clk   (clk),
    .reset (reset),
    .load  (cap),
    .blk   (core_data_i),
    .valid (out_valid_o),
    .ready (out_ready_i),
    .word  (out_word_o),
    .last  (out_last_o),
    .done  (done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_COLLECT;
      kcnt      <= 3'd0;
      dcnt      <= 2'd0;
      key_valid <= 1'b0;
      tcnt      <= '0;
      key_q     <= '0;
      data_q    <= '0;
      dec_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= bad_blk | tmo;

      if (key_acc) begin
        key_q[3'(KEY_WORDS - 1) - kcnt] <= in_word_i;
        if (kcnt == 3'(KEY_WORDS - 1)) begin
          kcnt      <= 3'd0;
          key_valid <= 1'b1;
        end else begin
          kcnt <= kcnt + 3'd1;
          if (kcnt == 3'd0)
            key_valid <= 1'b0;
        end
      end

      if (data_acc) begin
        data_q[~dcnt] <= in_word_i;
        dcnt          <= dcnt + 2'd1;
      end

      if (last_data)
        dec_q <= in_decrypt_i;

      unique case (state)
        ST_COLLECT: begin
          if (last_data && key_valid)
            state <= ST_LOAD;
        end
        ST_LOAD: begin
          tcnt  <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cap)
            state <= ST_DRAIN;
          else if (tmo)
            state <= ST_COLLECT;
          else
            tcnt <= tcnt + TW'(1);
        end
        ST_DRAIN: begin
          if (done)
            state <= ST_COLLECT;
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule
